// File: rtl/segre_mem_arbiter.sv
// segre_mem_arbiter: shares the single main-memory port between icache refill
// reads and dcache writeback/refill traffic. Each grant is registered, held on
// the memory port until mem_ready_i, and the line is returned to its owner
// with a one-cycle ready pulse. A dcache writeback+refill pair runs as one
// atomic write-then-read sequence.
// Optional feature: define SEGRE_MEM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests (default: fixed dcache priority).
module segre_mem_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned LINE_BYTES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    ic_rd_i,
    input  logic [ADDR_W-1:0]       ic_addr_i,
    output logic                    ic_ready_o,
    output logic [LINE_BYTES*8-1:0] ic_line_o,
    input  logic                    dc_rd_i,
    input  logic                    dc_wr_i,
    input  logic [ADDR_W-1:0]       dc_rd_addr_i,
    input  logic [ADDR_W-1:0]       dc_wr_addr_i,
    input  logic [LINE_BYTES*8-1:0] dc_line_i,
    output logic                    dc_ready_o,
    output logic [LINE_BYTES*8-1:0] dc_line_o,
    output logic                    mem_rd_o,
    output logic                    mem_wr_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic [LINE_BYTES*8-1:0] mem_line_o,
    input  logic [LINE_BYTES*8-1:0] mem_line_i,
    input  logic                    mem_ready_i,
    output logic                    grant_dc_o,
    output logic                    busy_o,
    output logic                    timeout_o
);

    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        IC_RD,
        DC_WR,
        DC_RD,
        RESP
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              pair_q;
    logic [WD_W-1:0]   wd_cnt_q;
    logic              dc_req;
    logic              pick_dc;
    logic              waiting;

`ifdef SEGRE_MEM_ARB_RR_EN
    logic              last_dc_q;
`endif

    // Winner selection among the requests visible in IDLE.
    always_comb begin
        dc_req = dc_rd_i | dc_wr_i;
`ifdef SEGRE_MEM_ARB_RR_EN
        pick_dc = dc_req & (~ic_rd_i | ~last_dc_q);
`else
        pick_dc = dc_req;
`endif
        waiting = (state_q == IC_RD) || (state_q == DC_WR) || (state_q == DC_RD);
    end

`ifdef SEGRE_MEM_ARB_RR_EN
    // Remember who won the most recent grant so ties alternate.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_dc_q <= 1'b0;
        end else if (state_q == IDLE && (dc_req || ic_rd_i)) begin
            last_dc_q <= pick_dc;
        end
    end
`endif

    // Transaction sequencer; every port-facing output is a register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rd_addr_q  <= '0;
            pair_q     <= 1'b0;
            ic_ready_o <= 1'b0;
            ic_line_o  <= '0;
            dc_ready_o <= 1'b0;
            dc_line_o  <= '0;
            mem_rd_o   <= 1'b0;
            mem_wr_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_line_o <= '0;
            grant_dc_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            ic_ready_o <= 1'b0;
            dc_ready_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_dc) begin
                        busy_o     <= 1'b1;
                        grant_dc_o <= 1'b1;
                        rd_addr_q  <= dc_rd_addr_i;
                        pair_q     <= dc_rd_i & dc_wr_i;
                        if (dc_wr_i) begin
                            state_q    <= DC_WR;
                            mem_wr_o   <= 1'b1;
                            mem_addr_o <= dc_wr_addr_i;
                            mem_line_o <= dc_line_i;
                        end else begin
                            state_q    <= DC_RD;
                            mem_rd_o   <= 1'b1;
                            mem_addr_o <= dc_rd_addr_i;
                        end
                    end else if (ic_rd_i) begin
                        busy_o     <= 1'b1;
                        grant_dc_o <= 1'b0;
                        state_q    <= IC_RD;
                        mem_rd_o   <= 1'b1;
                        mem_addr_o <= ic_addr_i;
                    end
                end
                IC_RD, DC_RD: begin
                    if (mem_ready_i) begin
                        mem_rd_o <= 1'b0;
                        state_q  <= RESP;
                        if (grant_dc_o) begin
                            dc_ready_o <= 1'b1;
                            dc_line_o  <= mem_line_i;
                        end else begin
                            ic_ready_o <= 1'b1;
                            ic_line_o  <= mem_line_i;
                        end
                    end
                end
                DC_WR: begin
                    if (mem_ready_i) begin
                        mem_wr_o <= 1'b0;
                        if (pair_q) begin
                            // Refill follows the writeback in the same cycle.
                            state_q    <= DC_RD;
                            mem_rd_o   <= 1'b1;
                            mem_addr_o <= rd_addr_q;
                        end else begin
                            state_q    <= RESP;
                            dc_ready_o <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state_q    <= IDLE;
                    busy_o     <= 1'b0;
                    grant_dc_o <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Watchdog: saturating count of cycles spent waiting on memory in the current state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_cnt_q  <= '0;
            timeout_o <= 1'b0;
        end else if (!waiting || mem_ready_i) begin
            wd_cnt_q <= '0;
        end else if (wd_cnt_q != WD_MAX) begin
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
            if (wd_cnt_q + WD_W'(1) == WD_MAX) begin
                timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Self-checking bench for segre_mem_arbiter: a transaction-level model predicts
// every output each cycle; directed scenarios add hand-computed literal checks.
module tb_segre_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LB = 16;
    localparam int unsigned LW = LB * 8;
    localparam int unsigned TO = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          ic_rd_i;
    logic [AW-1:0] ic_addr_i;
    logic          ic_ready_o;
    logic [LW-1:0] ic_line_o;
    logic          dc_rd_i;
    logic          dc_wr_i;
    logic [AW-1:0] dc_rd_addr_i;
    logic [AW-1:0] dc_wr_addr_i;
    logic [LW-1:0] dc_line_i;
    logic          dc_ready_o;
    logic [LW-1:0] dc_line_o;
    logic          mem_rd_o;
    logic          mem_wr_o;
    logic [AW-1:0] mem_addr_o;
    logic [LW-1:0] mem_line_o;
    logic [LW-1:0] mem_line_i;
    logic          mem_ready_i;
    logic          grant_dc_o;
    logic          busy_o;
    logic          timeout_o;

    always #5 clk_i = ~clk_i;

    segre_mem_arbiter #(
        .ADDR_W        (AW),
        .LINE_BYTES    (LB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ic_rd_i     (ic_rd_i),
        .ic_addr_i   (ic_addr_i),
        .ic_ready_o  (ic_ready_o),
        .ic_line_o   (ic_line_o),
        .dc_rd_i     (dc_rd_i),
        .dc_wr_i     (dc_wr_i),
        .dc_rd_addr_i(dc_rd_addr_i),
        .dc_wr_addr_i(dc_wr_addr_i),
        .dc_line_i   (dc_line_i),
        .dc_ready_o  (dc_ready_o),
        .dc_line_o   (dc_line_o),
        .mem_rd_o    (mem_rd_o),
        .mem_wr_o    (mem_wr_o),
        .mem_addr_o  (mem_addr_o),
        .mem_line_o  (mem_line_o),
        .mem_line_i  (mem_line_i),
        .mem_ready_i (mem_ready_i),
        .grant_dc_o  (grant_dc_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- requesters and memory stimulus ----------------
    typedef struct {
        bit            wr;
        bit            rd;
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        logic [LW-1:0] line;
    } dreq_t;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] line;
    } op_t;

    dreq_t         dq[$];
    logic [AW-1:0] iq[$];
    int            lat    = 2;
    bit            spur   = 1'b0;
    bit            use_a5 = 1'b0;

    function automatic logic [LW-1:0] mem_data(input logic [AW-1:0] a);
        if (use_a5) return {LB{8'hA5}};
        return {a, ~a, a ^ 32'h5A5A_0F0F, a + 32'h1111_1111};
    endfunction

    // ---------------- transaction-level model ----------------
    op_t           ops[$];
    bit            m_busy = 1'b0, m_resp = 1'b0, m_own_dc = 1'b0;
    bit            m_timeout = 1'b0, m_last_dc = 1'b0, m_line_ok = 1'b0;
    logic [LW-1:0] m_line = '0;
    int            m_age = 0, m_wait = 0;

    task automatic model_update();
        bit dreq, ireq, win_dc;
        if (rst_i) begin
            m_busy = 0; m_resp = 0; ops.delete();
            m_timeout = 0; m_last_dc = 0; m_wait = 0; m_age = 0;
        end else if (!m_busy) begin
            dreq = dq.size() > 0;
            ireq = iq.size() > 0;
`ifdef SEGRE_MEM_ARB_RR_EN
            win_dc = dreq && !(ireq && m_last_dc);
`else
            win_dc = dreq;
`endif
            if (win_dc) begin
                m_own_dc = 1;
                if (dq[0].wr) ops.push_back(op_t'{wr: 1'b1, addr: dq[0].wa, line: dq[0].line});
                if (dq[0].rd) ops.push_back(op_t'{wr: 1'b0, addr: dq[0].ra, line: '0});
            end else if (ireq) begin
                m_own_dc = 0;
                ops.push_back(op_t'{wr: 1'b0, addr: iq[0], line: '0});
            end
            if (ops.size() > 0) begin
                m_busy = 1; m_age = 1; m_wait = 0; m_last_dc = win_dc;
            end
        end else if (m_resp) begin
            m_busy = 0; m_resp = 0;
        end else if (mem_ready_i) begin
            m_line_ok = !ops[0].wr;
            if (!ops[0].wr) m_line = mem_line_i;
            void'(ops.pop_front());
            m_age = 1; m_wait = 0;
            if (ops.size() == 0) m_resp = 1;
        end else begin
            m_age++;
            if (m_wait < TO) m_wait++;
            if (m_wait == TO) m_timeout = 1;
        end
    endtask

    task automatic compare();
        bit strobe, e_rd, e_wr;
        strobe = m_busy && !m_resp && ops.size() > 0;
        e_rd   = strobe && !ops[0].wr;
        e_wr   = strobe && ops[0].wr;
        check("mem_rd_o", mem_rd_o, e_rd);
        check("mem_wr_o", mem_wr_o, e_wr);
        check("busy_o", busy_o, m_busy);
        check("grant_dc_o", grant_dc_o, m_busy && m_own_dc);
        check("timeout_o", timeout_o, m_timeout);
        check("ic_ready_o", ic_ready_o, m_resp && !m_own_dc);
        check("dc_ready_o", dc_ready_o, m_resp && m_own_dc);
        if (strobe) check("mem_addr_o", mem_addr_o, ops[0].addr);
        if (e_wr) check("mem_line_o", mem_line_o, ops[0].line);
        if (m_resp && m_line_ok && !m_own_dc) check("ic_line_o", ic_line_o, m_line);
        if (m_resp && m_line_ok && m_own_dc) check("dc_line_o", dc_line_o, m_line);
    endtask

    // ---------------- per-test logs of observed DUT values ----------------
    int            tc = 0;
    logic          log_rd[64], log_wr[64], log_icr[64], log_dcr[64], log_to[64], log_busy[64];
    logic [AW-1:0] log_addr[64];
    logic [LW-1:0] log_wline[64], log_rline[64];
    int            cnt_icr = 0, cnt_dcr = 0;
    bit            prev_busy = 1'b0;
    bit            glog[$];

    task automatic clear_logs();
        for (int i = 0; i < 64; i++) begin
            log_rd[i] = 0; log_wr[i] = 0; log_icr[i] = 0; log_dcr[i] = 0;
            log_to[i] = 0; log_busy[i] = 0; log_addr[i] = '0;
            log_wline[i] = '0; log_rline[i] = '0;
        end
        cnt_icr = 0; cnt_dcr = 0; tc = 0;
        glog.delete();
        prev_busy = busy_o;
    endtask

    task automatic log_cycle();
        if (tc < 64) begin
            log_rd[tc] = mem_rd_o; log_wr[tc] = mem_wr_o;
            log_icr[tc] = ic_ready_o; log_dcr[tc] = dc_ready_o;
            log_to[tc] = timeout_o; log_busy[tc] = busy_o;
            log_addr[tc] = mem_addr_o; log_wline[tc] = mem_line_o;
            log_rline[tc] = ic_ready_o ? ic_line_o : dc_line_o;
        end
        if (ic_ready_o) cnt_icr++;
        if (dc_ready_o) cnt_dcr++;
        if (busy_o && !prev_busy) glog.push_back(grant_dc_o);
        prev_busy = busy_o;
    endtask

    task automatic apply();
        bit active;
        ic_rd_i      = iq.size() > 0;
        ic_addr_i    = (iq.size() > 0) ? iq[0] : '0;
        dc_rd_i      = (dq.size() > 0) && dq[0].rd;
        dc_wr_i      = (dq.size() > 0) && dq[0].wr;
        dc_rd_addr_i = (dq.size() > 0) ? dq[0].ra : '0;
        dc_wr_addr_i = (dq.size() > 0) ? dq[0].wa : '0;
        dc_line_i    = (dq.size() > 0) ? dq[0].line : '0;
        active       = m_busy && !m_resp && ops.size() > 0;
        mem_ready_i  = spur || (active && lat != 0 && m_age >= lat);
        if (mem_ready_i && active && !ops[0].wr) mem_line_i = mem_data(ops[0].addr);
        else mem_line_i = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic step();
        @(posedge clk_i);
        model_update();
        tc++;
        #1;
        compare();
        log_cycle();
        // Requesters withdraw a request once its completion pulse is seen.
        if (m_resp && m_own_dc && dq.size() > 0) void'(dq.pop_front());
        if (m_resp && !m_own_dc && iq.size() > 0) void'(iq.pop_front());
        apply();
    endtask

    task automatic run(input int max);
        int n = 0;
        while ((m_busy || dq.size() > 0 || iq.size() > 0) && n < max) begin
            step();
            n++;
        end
        check("run_bound", n < max, 1'b1);
        step();
    endtask

    task automatic reset_pulse();
        rst_i = 1'b1; apply();
        step(); step();
        rst_i = 1'b0; apply();
    endtask

    logic [LW-1:0] wb_line;
    logic [7:0]    order;
    logic [7:0]    exp_order;

    initial begin
        rst_i = 1'b1;
        apply();

        // Reset state.
        reset_pulse();
        check("rst_mem_rd", mem_rd_o, 1'b0);
        check("rst_mem_addr", mem_addr_o, '0);
        check("rst_mem_line", mem_line_o, '0);
        check("rst_ic_line", ic_line_o, '0);
        check("rst_dc_line", dc_line_o, '0);
        check("rst_busy", busy_o, 1'b0);

        // Lone icache read, memory ready after 3 cycles.
        lat = 3; use_a5 = 1'b1;
        clear_logs();
        iq.push_back(32'h0000_0100);
        apply();
        run(40);
        check("ic_rd_c1", log_rd[1], 1'b1);
        check("ic_rd_c3", log_rd[3], 1'b1);
        check("ic_rd_c4", log_rd[4], 1'b0);
        check("ic_addr_c1", log_addr[1], 32'h100);
        check("ic_ready_c4", log_icr[4], 1'b1);
        check("ic_line_c4", log_rline[4], {LB{8'hA5}});
        check("ic_ready_cnt", cnt_icr, 1);
        check("ic_dc_ready_cnt", cnt_dcr, 0);
        use_a5 = 1'b0;

        // Writeback + refill pair.
        lat = 2;
        wb_line = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        clear_logs();
        dq.push_back(dreq_t'{wr: 1'b1, rd: 1'b1, wa: 32'h200, ra: 32'h300, line: wb_line});
        apply();
        run(40);
        check("wb_wr_c1", log_wr[1], 1'b1);
        check("wb_addr_c1", log_addr[1], 32'h200);
        check("wb_line_c1", log_wline[1], wb_line);
        check("wb_wr_c3", log_wr[3], 1'b0);
        check("wb_rd_c3", log_rd[3], 1'b1);
        check("wb_addr_c3", log_addr[3], 32'h300);
        check("wb_dc_ready_c5", log_dcr[5], 1'b1);
        check("wb_dc_line_c5", log_rline[5], {32'h300, ~32'h300, 32'h300 ^ 32'h5A5A_0F0F, 32'h1111_1411});
        check("wb_dc_ready_cnt", cnt_dcr, 1);

        // Contention: four dcache and four icache reads, fresh arbitration history.
        reset_pulse();
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            dq.push_back(dreq_t'{wr: 1'b0, rd: 1'b1, wa: '0, ra: 32'h400 + 32'(i * 16), line: '0});
            iq.push_back(32'h800 + 32'(i * 16));
        end
        apply();
        run(200);
        order = '0;
        foreach (glog[i]) order = {order[6:0], glog[i]};
`ifdef SEGRE_MEM_ARB_RR_EN
        exp_order = 8'b1010_1010;
`else
        exp_order = 8'b1111_0000;
`endif
        check("grant_count", glog.size(), 8);
        check("grant_order", order, exp_order);
        check("cont_ic_cnt", cnt_icr, 4);
        check("cont_dc_cnt", cnt_dcr, 4);

        // Spurious memory ready while idle.
        clear_logs();
        spur = 1'b1; apply();
        step(); step(); step();
        spur = 1'b0; apply();
        step();
        check("spur_busy", log_busy[1] | log_busy[2] | log_busy[3] | log_busy[4], 1'b0);
        check("spur_ready_cnt", cnt_icr + cnt_dcr, 0);

        // Memory never ready: watchdog, then reset mid-DC_RD.
        lat = 0;
        clear_logs();
        dq.push_back(dreq_t'{wr: 1'b0, rd: 1'b1, wa: '0, ra: 32'h500, line: '0});
        apply();
        for (int i = 0; i < 12; i++) step();
        check("wd_to_c8", log_to[8], 1'b0);
        check("wd_to_c9", log_to[9], 1'b1);
        check("wd_to_c12", log_to[12], 1'b1);
        check("wd_rd_c12", log_rd[12], 1'b1);
        check("wd_dc_ready_cnt", cnt_dcr, 0);
        rst_i = 1'b1; dq.delete(); apply();
        step();
        check("mid_rst_mem_rd", mem_rd_o, 1'b0);
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_grant", grant_dc_o, 1'b0);
        check("mid_rst_timeout", timeout_o, 1'b0);
        check("mid_rst_dc_ready", dc_ready_o, 1'b0);
        rst_i = 1'b0; lat = 2;
        clear_logs();
        dq.push_back(dreq_t'{wr: 1'b0, rd: 1'b1, wa: '0, ra: 32'h600, line: '0});
        apply();
        run(40);
        check("post_rst_ready_c3", log_dcr[3], 1'b1);
        check("post_rst_ready_cnt", cnt_dcr, 1);
        check("post_rst_line", log_rline[3], {32'h600, ~32'h600, 32'h600 ^ 32'h5A5A_0F0F, 32'h1111_1711});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish, expected completion");
        $fatal(1, "time limit");
    end

endmodule
